alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the combinational ALU. It keeps the legacy 3-bit add/sub/and/or/xor encoding and adds multi-cycle shift and multiply operations, a valid/ready handshake on input and output, and registered Z/N/C/V flags. It sits between an operand source, such as a register file or decoder, and a result sink that may stall.

Parameters:
W, 8, operand/result width in bits; W >= 2.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operands/op valid
in_ready  out  1  block can accept an operation this cycle
op  in  4  operation code (see Behaviour)
a  in  W  operand A
b  in  W  operand B / shift amount
ci  in  1  carry in (arith ops only)
out_valid  out  1  result valid
out_ready  in  1  sink accepts result
y  out  W  result
z  out  1  zero flag (y == 0)
n  out  1  negative flag (y[W-1])
c  out  1  carry flag
v  out  1  signed overflow flag
err  out  1  reserved/unsupported op

Behaviour:
- Reset (async, rst=1): state=IDLE; y=0; z=n=c=v=err=0; out_valid=0; in_ready=1 once rst deasserts. Reset mid-operation aborts it; no result is produced.
- Handshake:
  - Accept when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Result is delivered when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, y and all flags are held stable.
- States:
  - IDLE -> (accept, 1-cycle op) -> DONE
  - IDLE -> (accept, multi-cycle op) -> BUSY
  - BUSY -> (count exhausted) -> DONE
  - DONE -> (out_ready, no new accept) -> IDLE
  - DONE -> (out_ready && accept) -> DONE or BUSY; back-to-back, no bubble.
- op[3]=0, legacy encoding, op[2:0]=mux. The result is registered, so out_valid rises the cycle after accept (latency 1).
  - op[2] inverts b.
  - op[1:0] = 00 add: y = a + (b^{W{op[2]}}) + ci.
  - op[1:0] = 01 and, 10 or, 11 xor. These use the possibly inverted b.
  - Subtract is op=100 with ci=1.
  - Add/sub flags: c = carry out of bit W-1 (1 = no borrow for sub); v = signed overflow of the W-bit addition.
  - Logic-op flags: c=0, v=0.
- op=1000 SLL, 1001 SRL, 1010 SRA.
  - Amount k = min(b, W), unsigned.
  - One bit per cycle in BUSY; latency k+1 (k=0 -> 1).
  - c = last bit shifted out (0 if k=0); v=0.
  - k=W gives y=0 for SLL/SRL and y={W{a[W-1]}} for SRA.
- op=1011 MUL, unsigned, shift-add.
  - Latency W+1.
  - y = low W bits of a*b.
  - c = 1 iff the high W bits are nonzero; v=0.
- op=11xx is reserved: latency 1, y=0, err=1, c=v=0, z=1.
- err=0 for all valid ops.
- z and n are always derived from the final y.
- ci is ignored for non-arith ops.
- Operands are captured at accept; input changes during BUSY have no effect.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: MUL (op=1011) is implemented as above.
- Undefined:
  - No multiplier logic.
  - op=1011 is treated as reserved: latency 1, y=0, err=1, z=1.

Test Plan (W=4):
- Add, op=0000, a=7, b=9, ci=0, out_ready=1 -> out_valid 1 cycle after accept, y=0, c=1, z=1, v=0, n=0.
- Sub, op=0100, a=3, b=5, ci=1 -> y=4'hE, c=0, n=1, v=0; then a=4'h8, b=1 -> y=7, v=1, c=1.
- Shifts:
  - SRA a=4'b1000, b=2 -> out_valid exactly 3 cycles after accept, y=4'b1110, c=0.
  - SLL a=4'b1011, b=0 -> latency 1, y=4'b1011, c=0.
  - SRL a=4'hF, b=9 -> latency 5, y=0.
- MUL (macro defined) a=7, b=3 -> latency 5, y=5, c=1; a=5, b=3 -> y=15, c=0, n=1. With the macro undefined, the same op gives err=1, y=0 after 1 cycle.
- Back-pressure:
  - Hold out_ready=0 for 3 cycles after the result appears -> y and flags stable, in_ready=0.
  - Raise out_ready together with in_valid (AND 3 & 5) -> new accept in that cycle, y=1 next cycle, no idle bubble.
- Reset mid-MUL: assert rst 2 cycles after accept -> out_valid, y and flags drop to 0 immediately (async), in_ready=1 after release, no result emitted. Reserved op=1100 -> err=1, y=0, z=1.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake, multi-cycle shifts and an
// optional shift-add multiplier, enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] y,
    output logic         z,
    output logic         n,
    output logic         c,
    output logic         v,
    output logic         err
);
    localparam int CW = $clog2(W + 1);
    localparam logic [W-1:0]  W_VAL = W'(W);
    localparam logic [CW-1:0] W_CNT = CW'(W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_reg, state_next;
    logic [W-1:0]  y_reg, y_next;
    logic          z_reg, z_next, n_reg, n_next, c_reg, c_next;
    logic          v_reg, v_next, err_reg, err_next;
    logic [W-1:0]  work_reg, work_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [1:0]    kind_reg, kind_next;
`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]  hi_reg, hi_next, mcand_reg, mcand_next;
    logic [W:0]    mul_sum;
`endif

    logic          accept, load, shift_out;
    logic [W-1:0]  b_x;
    logic [W:0]    sum;
    logic [CW-1:0] k;

    for (genvar gi = 0; gi < W; gi++) begin : g_binv
        assign b_x[gi] = b[gi] ^ op[2];
    end

    assign sum      = {1'b0, a} + {1'b0, b_x} + {{W{1'b0}}, ci};
    assign k        = (b >= W_VAL) ? W_CNT : b[CW-1:0];
    assign in_ready = (state_reg == IDLE) || (state_reg == DONE && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        z_next     = z_reg;
        n_next     = n_reg;
        c_next     = c_reg;
        v_next     = v_reg;
        err_next   = err_reg;
        work_next  = work_reg;
        cnt_next   = cnt_reg;
        kind_next  = kind_reg;
        load       = 1'b0;
        shift_out  = 1'b0;
`ifdef ALU_SEQ_MUL_EN
        hi_next    = hi_reg;
        mcand_next = mcand_reg;
        mul_sum    = '0;
`endif
        case (state_reg)
            BUSY: begin
                cnt_next = cnt_reg - CW'(1);
                case (kind_reg)
                    2'b00: begin
                        work_next = {work_reg[W-2:0], 1'b0};
                        shift_out = work_reg[W-1];
                    end
                    2'b01: begin
                        work_next = {1'b0, work_reg[W-1:1]};
                        shift_out = work_reg[0];
                    end
                    2'b10: begin
                        work_next = {work_reg[W-1], work_reg[W-1:1]};
                        shift_out = work_reg[0];
                    end
                    default: begin
`ifdef ALU_SEQ_MUL_EN
                        // Product is built in {hi, work}; multiplier bits leave work from the bottom.
                        mul_sum   = {1'b0, hi_reg} + (work_reg[0] ? {1'b0, mcand_reg} : '0);
                        hi_next   = mul_sum[W:1];
                        work_next = {mul_sum[0], work_reg[W-1:1]};
`endif
                    end
                endcase
                if (cnt_reg == CW'(1)) begin
                    state_next = DONE;
                    load       = 1'b1;
                    y_next     = work_next;
                    c_next     = shift_out;
                    v_next     = 1'b0;
                    err_next   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
                    if (kind_reg == 2'b11) c_next = |hi_next;
`endif
                end
            end
            default: begin
                if (state_reg == DONE && out_ready) state_next = IDLE;
                if (accept) begin
                    state_next = DONE;
                    load       = 1'b1;
                    c_next     = 1'b0;
                    v_next     = 1'b0;
                    err_next   = 1'b0;
                    if (!op[3]) begin
                        case (op[1:0])
                            2'b00: begin
                                y_next = sum[W-1:0];
                                c_next = sum[W];
                                v_next = (a[W-1] == b_x[W-1]) && (sum[W-1] != a[W-1]);
                            end
                            2'b01:   y_next = a & b_x;
                            2'b10:   y_next = a | b_x;
                            default: y_next = a ^ b_x;
                        endcase
                    end else if (!op[2] && op[1:0] != 2'b11) begin
                        if (k == '0) begin
                            y_next = a;
                        end else begin
                            state_next = BUSY;
                            load       = 1'b0;
                            work_next  = a;
                            cnt_next   = k;
                            kind_next  = op[1:0];
                        end
`ifdef ALU_SEQ_MUL_EN
                    end else if (op[2:0] == 3'b011) begin
                        state_next = BUSY;
                        load       = 1'b0;
                        work_next  = b;
                        hi_next    = '0;
                        mcand_next = a;
                        cnt_next   = W_CNT;
                        kind_next  = 2'b11;
`endif
                    end else begin
                        y_next   = '0;
                        err_next = 1'b1;
                    end
                end
            end
        endcase
        if (load) begin
            z_next = ~|y_next;
            n_next = y_next[W-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            y_reg     <= '0;
            z_reg     <= 1'b0;
            n_reg     <= 1'b0;
            c_reg     <= 1'b0;
            v_reg     <= 1'b0;
            err_reg   <= 1'b0;
            work_reg  <= '0;
            cnt_reg   <= '0;
            kind_reg  <= '0;
`ifdef ALU_SEQ_MUL_EN
            hi_reg    <= '0;
            mcand_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            z_reg     <= z_next;
            n_reg     <= n_next;
            c_reg     <= c_next;
            v_reg     <= v_next;
            err_reg   <= err_next;
            work_reg  <= work_next;
            cnt_reg   <= cnt_next;
            kind_reg  <= kind_next;
`ifdef ALU_SEQ_MUL_EN
            hi_reg    <= hi_next;
            mcand_reg <= mcand_next;
`endif
        end
    end

    assign out_valid = (state_reg == DONE);
    assign y         = y_reg;
    assign z         = z_reg;
    assign n         = n_reg;
    assign c         = c_reg;
    assign v         = v_reg;
    assign err       = err_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (W=4): table of vectors through a scoreboard queue, plus
// back-pressure, back-to-back and reset-mid-operation sequences.
module tb_alu_seq;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, ci, out_valid, out_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b, y;
    logic         z, n, c, v, err;

    alu_seq #(.W(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .ci(ci), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .z(z), .n(n), .c(c), .v(v), .err(err)
    );

    always #5 clk = ~clk;

    // fl = {z, n, c, v, err}; lat = 0 means latency not checked
    typedef struct {
        int           id;
        logic [3:0]   op;
        logic [W-1:0] a, b;
        logic         ci;
        logic [W-1:0] y;
        logic [4:0]   fl;
        int           lat;
    } vec_t;
    typedef struct {
        vec_t e;
        int   acc;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[$];
    vec_t pend;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   acc_seen;

    function automatic vec_t mk(input int id, input logic [3:0] o, input logic [3:0] xa,
                                input logic [3:0] xb, input logic xci, input logic [3:0] xy,
                                input logic [4:0] xfl, input int xlat);
        vec_t t;
        t.id = id; t.op = o; t.a = xa; t.b = xb; t.ci = xci;
        t.y = xy; t.fl = xfl; t.lat = xlat;
        return t;
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Called just after a falling edge: checks a delivery / logs an accept
    // that the next rising edge will perform, then advances one cycle.
    task automatic tick();
        sb_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious: got result y=%0h with nothing pending, expected no result", y);
            end else begin
                e = sb.pop_front();
                chk("y", e.e.id, 32'(y), 32'(e.e.y));
                chk("flags", e.e.id, 32'({z, n, c, v, err}), 32'(e.e.fl));
                if (e.e.lat != 0) chk("latency", e.e.id, 32'(cyc - e.acc + 1), 32'(e.e.lat));
                $display("[TB] txn %0d op=%b a=%h b=%h -> y=%h znCVe=%b", e.e.id, e.e.op,
                         e.e.a, e.e.b, y, {z, n, c, v, err});
            end
        end
        if (in_valid && in_ready) begin
            acc_seen = 1'b1;
            e.e = pend;
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input vec_t t);
        op = t.op; a = t.a; b = t.b; ci = t.ci;
        in_valid = 1'b1;
        pend = t;
        acc_seen = 1'b0;
        for (int i = 0; i < 20 && !acc_seen; i++) tick();
        in_valid = 1'b0;
        // Scramble operands after accept; the in-flight op must not see them.
        a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom); op = 4'($urandom);
        chk("accept", t.id, 32'(acc_seen), 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
        chk("drain", 0, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; ci = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
        chk("rst_y", 0, 32'(y), 32'd0);
        chk("rst_flags", 0, 32'({z, n, c, v, err}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
        @(negedge clk);

        tbl.push_back(mk(1,  4'b0000, 4'd7,  4'd9,  1'b0, 4'h0, 5'b10100, 1));
        tbl.push_back(mk(2,  4'b0100, 4'd3,  4'd5,  1'b1, 4'hE, 5'b01000, 1));
        tbl.push_back(mk(3,  4'b0100, 4'h8,  4'd1,  1'b1, 4'h7, 5'b00110, 1));
        tbl.push_back(mk(4,  4'b0001, 4'hC,  4'hA,  1'b0, 4'h8, 5'b01000, 1));
        tbl.push_back(mk(5,  4'b0010, 4'h3,  4'h4,  1'b1, 4'h7, 5'b00000, 1));
        tbl.push_back(mk(6,  4'b0011, 4'h5,  4'h5,  1'b0, 4'h0, 5'b10000, 1));
        tbl.push_back(mk(7,  4'b0101, 4'hF,  4'h3,  1'b1, 4'hC, 5'b01000, 1));
        tbl.push_back(mk(8,  4'b0000, 4'hF,  4'h0,  1'b1, 4'h0, 5'b10100, 1));
        tbl.push_back(mk(9,  4'b1010, 4'b1000, 4'd2, 1'b0, 4'b1110, 5'b01000, 3));
        tbl.push_back(mk(10, 4'b1000, 4'b1011, 4'd0, 1'b0, 4'b1011, 5'b01000, 1));
        tbl.push_back(mk(11, 4'b1001, 4'hF,  4'd9,  1'b0, 4'h0, 5'b10100, 5));
        tbl.push_back(mk(12, 4'b1000, 4'h3,  4'd1,  1'b1, 4'h6, 5'b00000, 2));
        tbl.push_back(mk(13, 4'b1010, 4'h9,  4'd4,  1'b0, 4'hF, 5'b01100, 5));
        tbl.push_back(mk(14, 4'b1000, 4'h9,  4'd3,  1'b0, 4'h8, 5'b01000, 4));
        tbl.push_back(mk(15, 4'b1100, 4'h5,  4'h3,  1'b1, 4'h0, 5'b10001, 1));
        tbl.push_back(mk(16, 4'b1111, 4'hF,  4'hF,  1'b0, 4'h0, 5'b10001, 1));
`ifdef ALU_SEQ_MUL_EN
        tbl.push_back(mk(17, 4'b1011, 4'd7,  4'd3,  1'b0, 4'h5, 5'b00100, 5));
        tbl.push_back(mk(18, 4'b1011, 4'd5,  4'd3,  1'b0, 4'hF, 5'b01000, 5));
`else
        tbl.push_back(mk(17, 4'b1011, 4'd7,  4'd3,  1'b0, 4'h0, 5'b10001, 1));
        tbl.push_back(mk(18, 4'b1011, 4'd5,  4'd3,  1'b0, 4'h0, 5'b10001, 1));
`endif
        foreach (tbl[i]) begin
            send(tbl[i]);
            drain();
        end

        // Back-pressure: result must hold while the sink stalls.
        out_ready = 1'b0;
        send(mk(20, 4'b0000, 4'd3, 4'd5, 1'b0, 4'h8, 5'b01010, 0));
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 20, 32'(out_valid), 32'd1);
            chk("hold_y", 20, 32'(y), 32'h8);
            chk("hold_flags", 20, 32'({z, n, c, v, err}), 32'b01010);
            chk("hold_in_ready", 20, 32'(in_ready), 32'd0);
            tick();
        end

        // Release and issue the next op in the same cycle: no bubble (latency 1).
        out_ready = 1'b1;
        op = 4'b0001; a = 4'd3; b = 4'd5; ci = 1'b0; in_valid = 1'b1;
        pend = mk(21, 4'b0001, 4'd3, 4'd5, 1'b0, 4'h1, 5'b00000, 1);
        #1;
        chk("b2b_in_ready", 21, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("b2b_out_valid", 21, 32'(out_valid), 32'd1);
        drain();

        // Reset two cycles after accepting a MUL: abort without a result.
        send(mk(30, 4'b1011, 4'd7, 4'd3, 1'b0,
`ifdef ALU_SEQ_MUL_EN
                4'h5, 5'b00100, 5));
`else
                4'h0, 5'b10001, 1));
`endif
        tick();
        rst = 1'b1;
        #1;
        chk("abort_out_valid", 30, 32'(out_valid), 32'd0);
        chk("abort_y", 30, 32'(y), 32'd0);
        chk("abort_flags", 30, 32'({z, n, c, v, err}), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_in_ready", 30, 32'(in_ready), 32'd1);
        for (int i = 0; i < 8; i++) tick();
        chk("abort_no_result", 30, 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
